// File: rtl/event_pulse_stretcher_pkg.sv
// Shared types and helpers for the event pulse stretcher and its timer.
package event_pulse_stretcher_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // At least one bit, even when both intervals are a single cycle.
    function automatic int timer_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/interval_timer.sv
// Up-counter that clears on demand and holds once it reaches a runtime limit.
module interval_timer
    import event_pulse_stretcher_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         done
);

    assign done = (count == limit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (!done) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/event_pulse_stretcher.sv
// Turns single-cycle event strobes into fixed-length LED blinks with
// a mandatory off-gap, queueing events that arrive mid-blink.
module event_pulse_stretcher
    import event_pulse_stretcher_pkg::*;
#(
    parameter int ON_CYCLES  = 25_000_000,
    parameter int OFF_CYCLES = 25_000_000,
    parameter int PEND_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trig,
    input  logic              ovf_clr,
    output logic              led,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam int TW = timer_width(ON_CYCLES, OFF_CYCLES);
    localparam logic [TW-1:0] ON_LIM  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] OFF_LIM = TW'(OFF_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    state_t          state;
    state_t          state_nxt;
    logic [TW-1:0]   limit;
    logic [TW-1:0]   count;
    logic            done;
    logic            tmr_clear;
    logic            gap_last;
    logic            consume;
    logic            enq;
    logic            deq;
    logic            full;
    logic            drop;

    assign limit    = (state == ST_ON) ? ON_LIM : OFF_LIM;
    assign gap_last = (state == ST_GAP) && done;
    assign consume  = gap_last && (pending == '0) && trig;
    assign enq      = trig && ((state == ST_ON) ||
                               ((state == ST_GAP) && !consume));
    assign deq      = gap_last && (pending != '0);
    assign full     = (pending == PEND_MAX);
    assign drop     = enq && !deq && full;

    // Timer restarts on every state entry and idles at zero.
    assign tmr_clear = (state_nxt != state) || (state == ST_IDLE);

    interval_timer #(
        .W(TW)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (tmr_clear),
        .limit (limit),
        .count (count),
        .done  (done)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (trig) state_nxt = ST_ON;
            end
            ST_ON: begin
                if (done) state_nxt = ST_GAP;
            end
            ST_GAP: begin
                if (done) begin
                    if ((pending != '0) || trig) state_nxt = ST_ON;
                    else                         state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            led   <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            led   <= (state_nxt == ST_ON);
            busy  <= (state_nxt != ST_IDLE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else if (enq && !deq && !full) begin
            pending <= pending + PEND_W'(1);
        end else if (deq && !enq) begin
            pending <= pending - PEND_W'(1);
        end
    end

    // A drop in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_event_pulse_stretcher.sv
// Scoreboard bench for event_pulse_stretcher with ON=4, OFF=3, PEND_W=2.
module tb_event_pulse_stretcher;

    localparam int ON = 4;
    localparam int OFF = 3;
    localparam int PW = 2;
    localparam int PMAX = (1 << PW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic trig = 1'b0;
    logic ovf_clr = 1'b0;
    logic led;
    logic busy;
    logic [PW-1:0] pending;
    logic overflow;

    typedef struct packed {
        logic          led;
        logic          busy;
        logic [PW-1:0] pend;
        logic          ovf;
    } exp_t;

    exp_t sb[$];
    int   rises[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc;
    int   m_phase;
    int   m_left;
    int   m_pend;
    logic m_ovf;
    logic prev_led;
    logic o_led[64];
    logic o_busy[64];
    logic o_ovf[64];
    int   o_pend[64];

    event_pulse_stretcher #(
        .ON_CYCLES (ON),
        .OFF_CYCLES(OFF),
        .PEND_W    (PW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .trig    (trig),
        .ovf_clr (ovf_clr),
        .led     (led),
        .busy    (busy),
        .pending (pending),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d at cyc %0d",
                     tag, got, exp, cyc);
        end
    endtask

    function automatic int rise_at(input int k);
        if (k < rises.size()) return rises[k];
        return -1;
    endfunction

    // Behavioural model: phase plus cycles-left countdown.
    task automatic model_step(input logic t, input logic c);
        logic q;
        q = 1'b0;
        if (c) m_ovf = 1'b0;
        case (m_phase)
            0: begin
                if (t) begin m_phase = 1; m_left = ON; end
            end
            1: begin
                if (t) q = 1'b1;
                m_left--;
                if (m_left == 0) begin m_phase = 2; m_left = OFF; end
            end
            default: begin
                if (m_left == 1) begin
                    if (m_pend > 0) begin
                        if (!t) m_pend--;
                        m_phase = 1; m_left = ON;
                    end else if (t) begin
                        m_phase = 1; m_left = ON;
                    end else begin
                        m_phase = 0;
                    end
                end else begin
                    if (t) q = 1'b1;
                    m_left--;
                end
            end
        endcase
        if (q) begin
            if (m_pend == PMAX) m_ovf = 1'b1;
            else m_pend++;
        end
    endtask

    task automatic step(input logic t, input logic c);
        exp_t e;
        @(negedge clk);
        trig = t;
        ovf_clr = c;
        model_step(t, c);
        e.led  = (m_phase == 1);
        e.busy = (m_phase != 0);
        e.pend = PW'(m_pend);
        e.ovf  = m_ovf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            chk("led", led, e.led);
            chk("busy", busy, e.busy);
            chk("pending", pending, e.pend);
            chk("overflow", overflow, e.ovf);
        end
        if (cyc < 64) begin
            o_led[cyc]  = led;
            o_busy[cyc] = busy;
            o_ovf[cyc]  = overflow;
            o_pend[cyc] = int'(pending);
        end
        if (led && !prev_led) rises.push_back(cyc);
        prev_led = led;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        trig = 1'b0;
        ovf_clr = 1'b0;
        #1;
        chk("rst_led", led, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pend", pending, 0);
        chk("rst_ovf", overflow, 0);
        m_phase = 0; m_left = 0; m_pend = 0; m_ovf = 1'b0;
        cyc = 0; prev_led = 1'b0;
        rises.delete();
        sb.delete();
        for (int i = 0; i < 64; i++) begin
            o_led[i] = 1'b0; o_busy[i] = 1'b0;
            o_ovf[i] = 1'b0; o_pend[i] = 0;
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run(input logic [63:0] tm, input int len,
                       input int clr_at);
        for (int i = 0; i < len; i++) step(tm[i], i == clr_at);
        trig = 1'b0;
        ovf_clr = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // Single event
        do_reset();
        run(64'd1 << 10, 25, -1);
        chk("single_nrise", rises.size(), 1);
        chk("single_rise0", rise_at(0), 11);
        chk("single_led14", o_led[14], 1);
        chk("single_led15", o_led[15], 0);
        chk("single_busy17", o_busy[17], 1);
        chk("single_busy18", o_busy[18], 0);
        chk("single_pend12", o_pend[12], 0);

        // Burst of three
        do_reset();
        run((64'd1 << 10) | (64'd1 << 11) | (64'd1 << 12), 40, -1);
        chk("burst_nrise", rises.size(), 3);
        chk("burst_rise0", rise_at(0), 11);
        chk("burst_rise1", rise_at(1), 18);
        chk("burst_rise2", rise_at(2), 25);
        chk("burst_pend12", o_pend[12], 1);
        chk("burst_pend13", o_pend[13], 2);
        chk("burst_busy31", o_busy[31], 1);
        chk("burst_busy32", o_busy[32], 0);

        // Overflow and clear
        do_reset();
        run(64'h1F << 10, 50, 40);
        chk("ovf_pend14", o_pend[14], 3);
        chk("ovf_flag14", o_ovf[14], 0);
        chk("ovf_flag15", o_ovf[15], 1);
        chk("ovf_flag40", o_ovf[40], 1);
        chk("ovf_flag41", o_ovf[41], 0);
        chk("ovf_nrise", rises.size(), 4);
        chk("ovf_rise3", rise_at(3), 32);

        // Trig on last GAP cycle, nothing pending
        do_reset();
        run((64'd1 << 10) | (64'd1 << 17), 30, -1);
        chk("bnd0_nrise", rises.size(), 2);
        chk("bnd0_rise1", rise_at(1), 18);
        chk("bnd0_led17", o_led[17], 0);
        chk("bnd0_busy18", o_busy[18], 1);
        chk("bnd0_pend18", o_pend[18], 0);

        // Trig on last GAP cycle, one pending
        do_reset();
        run((64'd1 << 10) | (64'd1 << 11) | (64'd1 << 17), 40, -1);
        chk("bnd1_pend17", o_pend[17], 1);
        chk("bnd1_pend18", o_pend[18], 1);
        chk("bnd1_nrise", rises.size(), 3);
        chk("bnd1_rise2", rise_at(2), 25);

        // Asynchronous reset during ON with two pending
        do_reset();
        run(64'h7, 4, -1);
        chk("mid_pre_led", led, 1);
        chk("mid_pre_pend", pending, 2);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_led", led, 0);
        chk("mid_busy", busy, 0);
        chk("mid_pend", pending, 0);
        do_reset();
        run(64'd1 << 10, 25, -1);
        chk("post_nrise", rises.size(), 1);
        chk("post_rise0", rise_at(0), 11);
        chk("post_busy18", o_busy[18], 0);

        // Level held for three cycles
        do_reset();
        run(64'h7 << 5, 30, -1);
        chk("lvl_nrise", rises.size(), 3);
        chk("lvl_rise0", rise_at(0), 6);
        chk("lvl_rise1", rise_at(1), 13);
        chk("lvl_rise2", rise_at(2), 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
